// File: rtl/dedicated_datapath_pkg.sv
// Shared encodings for the datapath and its ControlUnit, kept in one place so
// the control words seen by both sides always decode the same way.
package dp_pkg;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_AND = 2'd2,
    ALU_OR  = 2'd3
  } alu_op_e;

  localparam logic RF_SRC_ALU = 1'b0;
  localparam logic RF_SRC_ONE = 1'b1;

  localparam int RF_ADDR_W = 3;
  localparam int NUM_REGS  = 1 << RF_ADDR_W;

endpackage

// File: rtl/dedicated_datapath_if.sv
// Output-port bundle: the datapath is the master of the FIFO head, the
// downstream consumer is the slave that returns out_ready.
interface dedicated_datapath_if #(
  parameter int DATA_W    = 8,
  parameter int OUT_DEPTH = 4
);
  localparam int CNT_W = $clog2(OUT_DEPTH) + 1;

  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_overflow;
  logic [CNT_W-1:0]  out_count;

  modport master (
    output out_data, out_valid, out_overflow, out_count,
    input  out_ready
  );

  modport slave (
    input  out_data, out_valid, out_overflow, out_count,
    output out_ready
  );
endinterface

// File: rtl/dedicated_datapath_out_fifo.sv
// Synchronous FIFO buffering values sent to the output port. The head is read
// straight from storage, so a pushed entry becomes visible one cycle later.
module dp_out_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [DATA_W-1:0]          i_data,
  output logic [DATA_W-1:0]          o_data,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_full,
  output logic                       o_empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_wr_en;
  logic              w_rd_en;

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = o_empty ? '0 : r_mem[r_rd_ptr];

  // When full, a simultaneous pop frees the slot the write lands in.
  assign w_wr_en = i_push & (~o_full | i_pop);
  assign w_rd_en = i_pop & ~o_empty;

  // NOTE: storage has no reset; the pointers and count define what is valid,
  // so clearing the array would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= i_data;
  end

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_wr_en, w_rd_en})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/dedicated_datapath.sv
// Datapath driven by the ControlUnit: register file, ALU, unsigned <= compare
// fed back as lte, and a buffered output port with sticky overflow reporting.
module dedicated_datapath
  import dp_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int OUT_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 RFSrcMuxSel,
  input  logic [RF_ADDR_W-1:0] RAddr1,
  input  logic [RF_ADDR_W-1:0] RAddr2,
  input  logic [RF_ADDR_W-1:0] WAddr,
  input  logic                 we,
  input  logic                 OutPortEn,
  input  alu_op_e              ALUop,
  output logic                 lte,
  dedicated_datapath_if.master out_port
);
  localparam int CNT_W = $clog2(OUT_DEPTH) + 1;

  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic              r_overflow;
  logic [DATA_W-1:0] w_rdata1;
  logic [DATA_W-1:0] w_rdata2;
  logic [DATA_W-1:0] w_alu;
  logic [DATA_W-1:0] w_wdata;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [DATA_W-1:0] w_fifo_data;
  logic [CNT_W-1:0]  w_fifo_count;

  // R0 is hardwired to zero on the read side; writes to it are dropped below.
  assign w_rdata1 = (RAddr1 == '0) ? '0 : r_regs[RAddr1];
  assign w_rdata2 = (RAddr2 == '0) ? '0 : r_regs[RAddr2];

  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_alu = '0;
    unique case (ALUop)
      ALU_ADD: w_alu = w_rdata1 + w_rdata2;
      ALU_SUB: w_alu = w_rdata1 - w_rdata2;
      ALU_AND: w_alu = w_rdata1 & w_rdata2;
      ALU_OR:  w_alu = w_rdata1 | w_rdata2;
    endcase
  end

  assign w_wdata = (RFSrcMuxSel == RF_SRC_ONE) ? DATA_W'(1) : w_alu;
  assign lte     = (w_rdata1 <= w_rdata2);

  // NOTE: the register file is cleared on reset because the control program
  // relies on starting from all-zero registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (we && (WAddr != '0)) begin
      r_regs[WAddr] <= w_wdata;
    end
  end

  assign w_pop = ~w_empty & out_port.out_ready;

  dp_out_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (OUT_DEPTH)
  ) u_out_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (OutPortEn),
    .i_pop   (w_pop),
    .i_data  (w_rdata1),
    .o_data  (w_fifo_data),
    .o_count (w_fifo_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // A push is only lost when the FIFO is full and nothing leaves that cycle.
  always_ff @(posedge clk) begin
    if (reset)                           r_overflow <= 1'b0;
    else if (OutPortEn & w_full & ~w_pop) r_overflow <= 1'b1;
  end

  assign out_port.out_data     = w_fifo_data;
  assign out_port.out_valid    = ~w_empty;
  assign out_port.out_count    = w_fifo_count;
  assign out_port.out_overflow = r_overflow;
endmodule

// File: tb/tb_dedicated_datapath.sv
// Directed bench for dedicated_datapath: register file, ALU, lte and the
// buffered output port, with registers observed through the output FIFO.
module tb_dedicated_datapath;
  import dp_pkg::*;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 RFSrcMuxSel;
  logic [RF_ADDR_W-1:0] RAddr1, RAddr2, WAddr;
  logic                 we, OutPortEn;
  alu_op_e              ALUop;
  logic                 lte;

  int n_compared   = 0;
  int n_mismatched = 0;

  dedicated_datapath_if #(.DATA_W(8), .OUT_DEPTH(4)) out_if ();

  dedicated_datapath #(.DATA_W(8), .OUT_DEPTH(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .RFSrcMuxSel (RFSrcMuxSel),
    .RAddr1      (RAddr1),
    .RAddr2      (RAddr2),
    .WAddr       (WAddr),
    .we          (we),
    .OutPortEn   (OutPortEn),
    .ALUop       (ALUop),
    .lte         (lte),
    .out_port    (out_if)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 1'b0; RFSrcMuxSel = RF_SRC_ALU; OutPortEn = 1'b0;
    RAddr1 = '0; RAddr2 = '0; WAddr = '0; ALUop = ALU_ADD;
    out_if.out_ready = 1'b0;
  endtask

  task automatic set_one(input logic [2:0] w);
    we = 1'b1; RFSrcMuxSel = RF_SRC_ONE; WAddr = w;
    step();
    we = 1'b0; RFSrcMuxSel = RF_SRC_ALU;
  endtask

  task automatic alu_write(input alu_op_e op, input logic [2:0] a, input logic [2:0] b,
                           input logic [2:0] w);
    we = 1'b1; RFSrcMuxSel = RF_SRC_ALU; ALUop = op; RAddr1 = a; RAddr2 = b; WAddr = w;
    step();
    we = 1'b0;
  endtask

  // Pushes R[addr] through an empty FIFO and returns the value seen at the head.
  task automatic read_reg(input logic [2:0] addr, output logic [7:0] v);
    we = 1'b0; out_if.out_ready = 1'b0; RAddr1 = addr; OutPortEn = 1'b1;
    step();
    OutPortEn = 1'b0;
    v = out_if.out_data;
    out_if.out_ready = 1'b1;
    step();
    out_if.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    n_compared++;
    if (out_if.out_valid !== 1'b0) begin
      n_mismatched++; $display("FAIL reset_valid: got %b want 0", out_if.out_valid);
    end
    n_compared++;
    if (out_if.out_count !== 3'd0) begin
      n_mismatched++; $display("FAIL reset_count: got %0d want 0", out_if.out_count);
    end
    n_compared++;
    if (out_if.out_overflow !== 1'b0) begin
      n_mismatched++; $display("FAIL reset_overflow: got %b want 0", out_if.out_overflow);
    end
    n_compared++;
    if (out_if.out_data !== 8'h00) begin
      n_mismatched++; $display("FAIL reset_data: got %h want 00", out_if.out_data);
    end
  endtask

  task automatic test_write_add();
    logic [7:0] v;
    set_one(3'd1);
    alu_write(ALU_ADD, 3'd1, 3'd1, 3'd2);
    read_reg(3'd2, v);
    n_compared++;
    if (v !== 8'd2) begin n_mismatched++; $display("FAIL add_r2: got %0d want 2", v); end
    read_reg(3'd1, v);
    n_compared++;
    if (v !== 8'd1) begin n_mismatched++; $display("FAIL const_r1: got %0d want 1", v); end
    // Write R3 and push R3 in the same cycle: the FIFO must capture the old value.
    we = 1'b1; RFSrcMuxSel = RF_SRC_ONE; WAddr = 3'd3; RAddr1 = 3'd3; OutPortEn = 1'b1;
    step();
    we = 1'b0; RFSrcMuxSel = RF_SRC_ALU; OutPortEn = 1'b0;
    n_compared++;
    if (out_if.out_data !== 8'd0 || out_if.out_valid !== 1'b1) begin
      n_mismatched++;
      $display("FAIL no_bypass: got data %0d valid %b want 0/1", out_if.out_data, out_if.out_valid);
    end
    out_if.out_ready = 1'b1;
    step();
    out_if.out_ready = 1'b0;
    read_reg(3'd3, v);
    n_compared++;
    if (v !== 8'd1) begin n_mismatched++; $display("FAIL next_cycle_r3: got %0d want 1", v); end
  endtask

  task automatic test_alu();
    logic [7:0] v;
    alu_write(ALU_AND, 3'd0, 3'd1, 3'd2);
    alu_write(ALU_SUB, 3'd2, 3'd1, 3'd3);
    read_reg(3'd3, v);
    n_compared++;
    if (v !== 8'hFF) begin n_mismatched++; $display("FAIL sub_wrap: got %h want ff", v); end
    alu_write(ALU_ADD, 3'd1, 3'd1, 3'd4);
    alu_write(ALU_ADD, 3'd4, 3'd4, 3'd4);
    alu_write(ALU_ADD, 3'd4, 3'd4, 3'd4);
    alu_write(ALU_ADD, 3'd4, 3'd4, 3'd4);
    alu_write(ALU_SUB, 3'd4, 3'd1, 3'd5);
    read_reg(3'd5, v);
    n_compared++;
    if (v !== 8'h0F) begin n_mismatched++; $display("FAIL build_0f: got %h want 0f", v); end
    alu_write(ALU_ADD, 3'd5, 3'd5, 3'd6);
    alu_write(ALU_ADD, 3'd6, 3'd6, 3'd6);
    read_reg(3'd6, v);
    n_compared++;
    if (v !== 8'h3C) begin n_mismatched++; $display("FAIL build_3c: got %h want 3c", v); end
    alu_write(ALU_AND, 3'd5, 3'd6, 3'd7);
    read_reg(3'd7, v);
    n_compared++;
    if (v !== 8'h0C) begin n_mismatched++; $display("FAIL and_op: got %h want 0c", v); end
    alu_write(ALU_OR, 3'd5, 3'd6, 3'd7);
    read_reg(3'd7, v);
    n_compared++;
    if (v !== 8'h3F) begin n_mismatched++; $display("FAIL or_op: got %h want 3f", v); end
    alu_write(ALU_ADD, 3'd3, 3'd1, 3'd7);
    read_reg(3'd7, v);
    n_compared++;
    if (v !== 8'h00) begin n_mismatched++; $display("FAIL add_wrap: got %h want 00", v); end
    alu_write(ALU_SUB, 3'd1, 3'd5, 3'd7);
    read_reg(3'd7, v);
    n_compared++;
    if (v !== 8'hF2) begin n_mismatched++; $display("FAIL sub_order: got %h want f2", v); end
  endtask

  task automatic test_lte();
    logic [7:0] v;
    alu_write(ALU_ADD, 3'd1, 3'd1, 3'd4);
    alu_write(ALU_ADD, 3'd1, 3'd1, 3'd2);
    RAddr1 = 3'd4; RAddr2 = 3'd2; #1;
    n_compared++;
    if (lte !== 1'b1) begin n_mismatched++; $display("FAIL lte_equal: got %b want 1", lte); end
    alu_write(ALU_ADD, 3'd4, 3'd1, 3'd4);
    RAddr1 = 3'd4; RAddr2 = 3'd2; #1;
    n_compared++;
    if (lte !== 1'b0) begin n_mismatched++; $display("FAIL lte_greater: got %b want 0", lte); end
    RAddr1 = 3'd0; #1;
    n_compared++;
    if (lte !== 1'b1) begin n_mismatched++; $display("FAIL lte_r0: got %b want 1", lte); end
    RAddr1 = 3'd3; RAddr2 = 3'd2; #1;
    n_compared++;
    if (lte !== 1'b0) begin n_mismatched++; $display("FAIL lte_unsigned: got %b want 0", lte); end
    set_one(3'd0);
    alu_write(ALU_OR, 3'd3, 3'd3, 3'd0);
    read_reg(3'd0, v);
    n_compared++;
    if (v !== 8'h00) begin n_mismatched++; $display("FAIL r0_write: got %h want 00", v); end
    RAddr1 = 3'd1; RAddr2 = 3'd0; #1;
    n_compared++;
    if (lte !== 1'b0) begin n_mismatched++; $display("FAIL lte_vs_r0: got %b want 0", lte); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_q [4];
    exp_q = '{8'd2, 8'd3, 8'd4, 8'd9};
    set_one(3'd1);
    alu_write(ALU_ADD, 3'd1, 3'd1, 3'd2);
    alu_write(ALU_ADD, 3'd2, 3'd1, 3'd3);
    alu_write(ALU_ADD, 3'd3, 3'd1, 3'd4);
    alu_write(ALU_ADD, 3'd4, 3'd1, 3'd5);
    alu_write(ALU_ADD, 3'd4, 3'd5, 3'd6);
    out_if.out_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      RAddr1 = 3'(k); OutPortEn = 1'b1;
      step();
    end
    OutPortEn = 1'b0;
    n_compared++;
    if (out_if.out_count !== 3'd4 || out_if.out_data !== 8'd1) begin
      n_mismatched++;
      $display("FAIL fill: got count %0d head %0d want 4/1", out_if.out_count, out_if.out_data);
    end
    RAddr1 = 3'd6; OutPortEn = 1'b1; out_if.out_ready = 1'b1;
    step();
    OutPortEn = 1'b0; out_if.out_ready = 1'b0;
    n_compared++;
    if (out_if.out_count !== 3'd4) begin
      n_mismatched++; $display("FAIL full_pushpop_count: got %0d want 4", out_if.out_count);
    end
    n_compared++;
    if (out_if.out_overflow !== 1'b0) begin
      n_mismatched++; $display("FAIL full_pushpop_ovf: got %b want 0", out_if.out_overflow);
    end
    out_if.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_compared++;
      if (out_if.out_valid !== 1'b1 || out_if.out_data !== exp_q[i]) begin
        n_mismatched++;
        $display("FAIL pushpop_drain[%0d]: got %0d valid %b want %0d", i, out_if.out_data,
                 out_if.out_valid, exp_q[i]);
      end
      step();
    end
    out_if.out_ready = 1'b0;
    n_compared++;
    if (out_if.out_valid !== 1'b0 || out_if.out_count !== 3'd0) begin
      n_mismatched++;
      $display("FAIL pushpop_empty: got valid %b count %0d want 0/0", out_if.out_valid,
               out_if.out_count);
    end
  endtask

  task automatic test_overflow();
    out_if.out_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      RAddr1 = 3'(k); OutPortEn = 1'b1;
      step();
      if (k == 4) begin
        n_compared++;
        if (out_if.out_count !== 3'd4 || out_if.out_overflow !== 1'b0) begin
          n_mismatched++;
          $display("FAIL ovf_pre: got count %0d ovf %b want 4/0", out_if.out_count,
                   out_if.out_overflow);
        end
      end
    end
    OutPortEn = 1'b0;
    n_compared++;
    if (out_if.out_count !== 3'd4 || out_if.out_overflow !== 1'b1) begin
      n_mismatched++;
      $display("FAIL ovf_set: got count %0d ovf %b want 4/1", out_if.out_count,
               out_if.out_overflow);
    end
    out_if.out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      n_compared++;
      if (out_if.out_valid !== 1'b1 || out_if.out_data !== 8'(i)) begin
        n_mismatched++;
        $display("FAIL ovf_drain[%0d]: got %0d valid %b want %0d", i, out_if.out_data,
                 out_if.out_valid, i);
      end
      step();
    end
    out_if.out_ready = 1'b0;
    n_compared++;
    if (out_if.out_valid !== 1'b0 || out_if.out_overflow !== 1'b1) begin
      n_mismatched++;
      $display("FAIL ovf_after: got valid %b ovf %b want 0/1", out_if.out_valid,
               out_if.out_overflow);
    end
  endtask

  task automatic test_reset_mid_stream();
    logic [7:0] v;
    out_if.out_ready = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      RAddr1 = 3'(k); OutPortEn = 1'b1;
      step();
    end
    OutPortEn = 1'b0;
    n_compared++;
    if (out_if.out_count !== 3'd2) begin
      n_mismatched++; $display("FAIL mid_fill: got %0d want 2", out_if.out_count);
    end
    reset = 1'b1; we = 1'b1; RFSrcMuxSel = RF_SRC_ONE; WAddr = 3'd3;
    RAddr1 = 3'd1; OutPortEn = 1'b1; out_if.out_ready = 1'b1;
    step();
    reset = 1'b0;
    idle();
    n_compared++;
    if (out_if.out_valid !== 1'b0 || out_if.out_count !== 3'd0) begin
      n_mismatched++;
      $display("FAIL mid_reset_fifo: got valid %b count %0d want 0/0", out_if.out_valid,
               out_if.out_count);
    end
    n_compared++;
    if (out_if.out_overflow !== 1'b0 || out_if.out_data !== 8'h00) begin
      n_mismatched++;
      $display("FAIL mid_reset_ovf_data: got ovf %b data %h want 0/00", out_if.out_overflow,
               out_if.out_data);
    end
    step();
    n_compared++;
    if (out_if.out_valid !== 1'b0) begin
      n_mismatched++; $display("FAIL mid_reset_late: got valid %b want 0", out_if.out_valid);
    end
    for (int r = 1; r <= 3; r++) begin
      read_reg(3'(r), v);
      n_compared++;
      if (v !== 8'h00) begin
        n_mismatched++; $display("FAIL mid_reset_r%0d: got %h want 00", r, v);
      end
    end
  endtask

  initial begin
    idle();
    reset = 1'b1;
    test_reset();
    test_write_add();
    test_alu();
    test_lte();
    test_back_to_back();
    test_overflow();
    test_reset_mid_stream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end
endmodule
